// File: rtl/serial_addsub_ctrl_pkg.sv
// serial_addsub_ctrl_pkg: shared widths and FSM encoding for the serial add/sub controller
package serial_addsub_ctrl_pkg;
  localparam int SLICE_W = 5;
  localparam int NUM_SLICES = 4;
  localparam int W = SLICE_W * NUM_SLICES;
  localparam int IDX_W = 2;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/addsub_slice.sv
// addsub_slice: combinational ripple add/sub slice exposing carry into the MSB for overflow
module addsub_slice
  import serial_addsub_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               invert,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout,
  output logic               c_msb_in
);
  logic [SLICE_W-1:0] bx;
  logic [SLICE_W-1:0] lo;
  logic [1:0]         hi;
  assign bx = b ^ {SLICE_W{invert}};
  assign lo = {1'b0, a[SLICE_W-2:0]} + {1'b0, bx[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin};
  assign c_msb_in = lo[SLICE_W-1];
  assign hi = {1'b0, a[SLICE_W-1]} + {1'b0, bx[SLICE_W-1]} + {1'b0, c_msb_in};
  assign sum = {hi[0], lo[SLICE_W-2:0]};
  assign cout = hi[1];
endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: 20-bit add/sub by four passes through one 5-bit slice with a registered carry
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         overflow
);
  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic               carry_reg;
  logic               op_r;
  logic [W-1:0]       xr, yr, acc, acc_next;
  logic [SLICE_W-1:0] sum;
  logic               cout, c_msb_in;
  logic               last;
  assign last = idx == IDX_W'(NUM_SLICES - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  addsub_slice u_slice (
    .a        (xr[idx*SLICE_W +: SLICE_W]),
    .b        (yr[idx*SLICE_W +: SLICE_W]),
    .invert   (op_r),
    .cin      (carry_reg),
    .sum      (sum),
    .cout     (cout),
    .c_msb_in (c_msb_in)
  );
  // merge the slice just computed so the final edge can publish the full word
  always_comb begin
    acc_next = acc;
    acc_next[idx*SLICE_W +: SLICE_W] = sum;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  // next-state: start only honoured in IDLE, DONE lasts exactly one cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = last ? DONE : RUN;
      default: state_next = IDLE;
    endcase
  end
  // operand latch, per-pass carry/index stepping, and result publish on the last pass
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xr <= '0;
      yr <= '0;
      op_r <= 1'b0;
      idx <= '0;
      carry_reg <= 1'b0;
      acc <= '0;
      result <= '0;
      carry_out <= 1'b0;
      overflow <= 1'b0;
    end else if (state == IDLE && start) begin
      xr <= x;
      yr <= y;
      op_r <= op_sub;
      idx <= '0;
      carry_reg <= op_sub;
      acc <= '0;
    end else if (state == RUN) begin
      acc <= acc_next;
      carry_reg <= cout;
      idx <= idx + 1'b1;
      if (last) begin
        result <= acc_next;
        carry_out <= cout;
        overflow <= c_msb_in ^ cout;
      end
    end
  end
endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Sequencer that performs a 20-bit add or subtract by driving one 5-bit ripple add/sub slice four times, least-significant slice first.
- Rippling the carry between passes is a register, not a wire; the block has a start/busy/done handshake.
- It is the multi-word controller placed above the 5-bit add/sub datapath.
- It reports the same flags as that datapath, widened to 20 bits: carry out of the top bit and signed overflow E.

Parameters:
- SLICE_W, 5, width of one add/sub slice in bits.
- NUM_SLICES, 4, number of slice passes; operand width W = SLICE_W*NUM_SLICES = 20.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op_sub  input  1  0 = X+Y, 1 = X-Y; sampled with start.
- x  input  W  operand X, unsigned or two's complement; sampled with start.
- y  input  W  operand Y; sampled with start.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle completion pulse.
- result  output  W  X±Y modulo 2^W.
- carry_out  output  1  carry out of bit W-1. For subtract, 1 means no borrow.
- overflow  output  1  carry into bit W-1 XOR carry out of bit W-1 (E).

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0.
  - Internal operand, accumulator, index and carry registers all 0.
- States are IDLE, RUN and DONE.
- IDLE:
  - On start=1 at edge E0: latch x, y, op_sub; idx=0; carry_reg=op_sub; go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1), at each edge:
  - The slice computes acc[idx] = x[idx] + (y[idx] XOR {SLICE_W{op}}) + carry_reg.
  - carry_reg <= slice cout; idx <= idx+1.
  - On the last slice (idx=NUM_SLICES-1, edge E4):
    - result <= full accumulator, including the slice just computed.
    - carry_out <= slice cout.
    - overflow <= slice carry-into-MSB XOR slice cout.
    - Go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency:
  - done is high in the cycle after E4, i.e. 4 cycles after the start-sampling edge.
  - Throughput is one operation per NUM_SLICES+2 cycles.
- start while in RUN or DONE is ignored and not queued. Operands/op are not re-sampled.
- result, carry_out and overflow change only on the final RUN edge. They hold until the next completion; partial slices are never visible.
- Y inversion is applied per slice by the controller. Carry-in of slice 0 = op_sub; slices 1..3 take carry_reg.
- idx is a 2-bit counter that wraps to 0. An idx value beyond NUM_SLICES-1 is unreachable.
- rst_n low mid-RUN aborts immediately:
  - All outputs return to reset values.
  - No done pulse.
  - The next start after release runs a fresh operation.
- Unsigned wrap: 0xFFFFF+1 gives result 0, carry_out 1.

Decomposition:
- Shared package: SLICE_W, NUM_SLICES, W, and the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- One sub-module, addsub_slice: combinational SLICE_W-bit ripple adder.
  - Inputs: a, b, invert, cin.
  - Outputs: sum, cout, c_msb_in (carry into the slice MSB, used for overflow).
  - Invert and carry-in are separate inputs, so carry can chain across passes.
- The controller holds the FSM, index counter, carry register, operand/accumulator registers and output registers.

Test Plan:
1. Add, x=12345, y=54321, op_sub=0, one-cycle start:
   - busy high 4 cycles; done pulse 4 cycles after start edge.
   - result=66666 (0x1046A), carry_out=0, overflow=0.
2. Add, x=0x7FFFF, y=0x00001:
   - result=0x80000, overflow=1, carry_out=0.
   - Then x=0xFFFFF, y=0x00001: result=0x00000, carry_out=1, overflow=0.
3. Subtract, x=5, y=7: result=0xFFFFE, carry_out=0, overflow=0. Then x=7, y=5: result=2, carry_out=1, overflow=0.
4. Subtract, x=0x80000, y=0x00001: result=0x7FFFF, carry_out=1, overflow=1.
5. Hold start=1 continuously with changing x/y during RUN:
   - Exactly one done per NUM_SLICES+2 cycles.
   - Each result matches the operands latched at its own start edge.
6. Assert rst_n low on the second RUN cycle of a 12345+54321 add:
   - Outputs go to 0 asynchronously; no done.
   - After release, start x=1, y=2 add gives result=3 with done at the normal latency.
